// File: rtl/edge_binarize_stream_pkg.sv
// rtl/edge_binarize_stream_pkg.sv - shared types and sizing helpers for the edge binariser
package edge_binarize_stream_pkg;

  typedef enum logic [1:0] {
    MODE_THRESH = 2'd0,
    MODE_TRANS  = 2'd1,
    MODE_HYST   = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  function automatic int cnt_w(input int img_w, input int img_h);
    return $clog2(img_w * img_h + 1);
  endfunction

  // A position counter for a dimension of size 1 still needs one bit.
  function automatic int pos_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/edge_binarize_stream_if.sv
// rtl/edge_binarize_stream_if.sv - pixel input and tagged output stream bundle
interface edge_binarize_stream_if #(
  parameter int DATA_W = 8
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_sof;
  logic              m_eol;
  logic              m_eof;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eol, m_eof
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eol, m_eof
  );

endinterface

// File: rtl/edge_pix_classify.sv
// rtl/edge_pix_classify.sv - per-pixel edge decision for all four modes
module edge_pix_classify
  import edge_binarize_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] prev,
  input  logic              prev_edge,
  input  logic              first,
  input  mode_e             mode,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  output logic              is_edge,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] lo_eff;
  logic [DATA_W-1:0] diff;

  always_comb begin
    lo_eff   = (lo > hi) ? hi : lo;
    diff     = (d >= prev) ? (d - prev) : (prev - d);
    is_edge  = 1'b0;
    out_data = '0;
    case (mode)
      MODE_THRESH: is_edge = (d >= hi);
      MODE_TRANS:  is_edge = !first && (diff >= hi);
      // The weak threshold only extends a run that is already in progress on this line.
      MODE_HYST:   is_edge = (d >= hi) || (!first && prev_edge && (d >= lo_eff));
      MODE_BYPASS: is_edge = (d >= hi);
      default:     is_edge = 1'b0;
    endcase
    if (mode == MODE_BYPASS) begin
      out_data = d;
    end else begin
      out_data = is_edge ? {DATA_W{1'b1}} : '0;
    end
  end

endmodule

// File: rtl/edge_binarize_stream.sv
// rtl/edge_binarize_stream.sv - streaming gradient binariser with position tags and per-frame edge count
module edge_binarize_stream
  import edge_binarize_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int CNT_W  = cnt_w(IMG_W, IMG_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync_clr,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_W-1:0]     cfg_thr_hi,
  input  logic [DATA_W-1:0]     cfg_thr_lo,
  edge_binarize_stream_if.slave bus,
  output logic [CNT_W-1:0]      frame_edge_cnt,
  output logic                  frame_done
);

  localparam int X_W = pos_w(IMG_W);
  localparam int Y_W = pos_w(IMG_H);
  localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IMG_W * IMG_H);

  state_e            state_q;
  mode_e             mode_q;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [CNT_W-1:0]  run_q;
  logic [DATA_W-1:0] prev_q;
  logic              prev_edge_q;
  logic              m_valid_q, m_sof_q, m_eol_q, m_eof_q;
  logic [DATA_W-1:0] m_data_q;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic              frame_done_q;

  logic              s_ready_d;
  logic              xfer_d;
  logic              at_eol_d, at_eof_d;
  mode_e             mode_d;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic              px_edge_d;
  logic [DATA_W-1:0] px_data_d;
  logic [CNT_W-1:0]  run_d;

  always_comb begin
    s_ready_d = !m_valid_q || bus.m_ready;
    xfer_d    = bus.s_valid && s_ready_d && !sync_clr;
    at_eol_d  = (x_q == X_LAST);
    at_eof_d  = at_eol_d && (y_q == Y_LAST);
    // The frame's first pixel is classified with the live config it is about to latch.
    if (state_q == ST_IDLE) begin
      mode_d = mode_e'(cfg_mode);
      hi_d   = cfg_thr_hi;
      lo_d   = cfg_thr_lo;
    end else begin
      mode_d = mode_q;
      hi_d   = hi_q;
      lo_d   = lo_q;
    end
    run_d = (px_edge_d && (run_q != CNT_MAX)) ? run_q + 1'b1 : run_q;
  end

  edge_pix_classify #(
    .DATA_W (DATA_W)
  ) u_classify (
    .d         (bus.s_data),
    .prev      (prev_q),
    .prev_edge (prev_edge_q),
    .first     (x_q == '0),
    .mode      (mode_d),
    .hi        (hi_d),
    .lo        (lo_d),
    .is_edge   (px_edge_d),
    .out_data  (px_data_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_THRESH;
      hi_q         <= '0;
      lo_q         <= '0;
      x_q          <= '0;
      y_q          <= '0;
      run_q        <= '0;
      prev_q       <= '0;
      prev_edge_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_sof_q      <= 1'b0;
      m_eol_q      <= 1'b0;
      m_eof_q      <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else if (sync_clr) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      run_q        <= '0;
      prev_q       <= '0;
      prev_edge_q  <= 1'b0;
      m_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
      if (xfer_d) begin
        m_valid_q   <= 1'b1;
        m_data_q    <= px_data_d;
        m_sof_q     <= (x_q == '0) && (y_q == '0);
        m_eol_q     <= at_eol_d;
        m_eof_q     <= at_eof_d;
        prev_q      <= bus.s_data;
        prev_edge_q <= px_edge_d;
        if (state_q == ST_IDLE) begin
          state_q <= ST_ACTIVE;
          mode_q  <= mode_e'(cfg_mode);
          hi_q    <= cfg_thr_hi;
          lo_q    <= cfg_thr_lo;
        end
        if (at_eol_d) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
        if (at_eof_d) begin
          frame_cnt_q  <= run_d;
          frame_done_q <= 1'b1;
          run_q        <= '0;
          state_q      <= ST_IDLE;
        end else begin
          run_q <= run_d;
        end
      end
    end
  end

  assign bus.s_ready    = s_ready_d;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.m_sof      = m_sof_q;
  assign bus.m_eol      = m_eol_q;
  assign bus.m_eof      = m_eof_q;
  assign frame_edge_cnt = frame_cnt_q;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_edge_binarize_stream.sv
// tb/tb_edge_binarize_stream.sv - directed self-checking bench for edge_binarize_stream (4x2 frames)
module tb_edge_binarize_stream;

  logic       clk;
  logic       rst;
  logic       sync_clr;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_thr_hi;
  logic [7:0] cfg_thr_lo;
  logic [3:0] frame_edge_cnt;
  logic       frame_done;
  int         checks;
  int         errors;

  edge_binarize_stream_if #(.DATA_W(8)) bus ();

  edge_binarize_stream #(
    .DATA_W (8),
    .IMG_W  (4),
    .IMG_H  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sync_clr       (sync_clr),
    .cfg_mode       (cfg_mode),
    .cfg_thr_hi     (cfg_thr_hi),
    .cfg_thr_lo     (cfg_thr_lo),
    .bus            (bus),
    .frame_edge_cnt (frame_edge_cnt),
    .frame_done     (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Offers one pixel and returns 1 time unit after the edge that accepts it.
  task automatic send_pix(input logic [7:0] d);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    #1;
    while (!bus.s_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL send_pix timeout s_ready=%b required 1", bus.s_ready);
    end
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got %h required 000", {bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof});
    end
    checks++;
    if ({frame_edge_cnt, frame_done} !== 5'h00) begin
      errors++;
      $display("FAIL reset_count got cnt=%0d done=%b required 0/0", frame_edge_cnt, frame_done);
    end
    checks++;
    if (bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready got %b required 1", bus.s_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_thresh();
    logic [7:0] px  [8];
    logic [7:0] exp [8];
    px  = '{8'h00, 8'h80, 8'h7F, 8'hFF, 8'h10, 8'h90, 8'h00, 8'hFF};
    exp = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    cfg_mode = 2'd0; cfg_thr_hi = 8'h80; cfg_thr_lo = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_pix(px[i]);
      checks++;
      if ({bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof} !== {1'b1, exp[i], i == 0, i % 4 == 3, i == 7}) begin
        errors++;
        $display("FAIL thresh_px%0d got v=%b d=%h sof/eol/eof=%b%b%b required d=%h", i, bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof, exp[i]);
      end
    end
    checks++;
    if ({frame_done, frame_edge_cnt} !== {1'b1, 4'd4}) begin
      errors++;
      $display("FAIL thresh_count got done=%b cnt=%0d required 1/4", frame_done, frame_edge_cnt);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({frame_done, bus.m_valid} !== 2'b00) begin
      errors++;
      $display("FAIL thresh_done_pulse got done=%b v=%b required 0/0", frame_done, bus.m_valid);
    end
  endtask

  task automatic test_trans();
    logic [7:0] px  [8];
    logic [7:0] exp [8];
    px  = '{8'h10, 8'h60, 8'h70, 8'h20, 8'hFF, 8'hF0, 8'h10, 8'h10};
    exp = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
    cfg_mode = 2'd1; cfg_thr_hi = 8'h40;
    for (int i = 0; i < 8; i++) begin
      send_pix(px[i]);
      checks++;
      if ({bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof} !== {1'b1, exp[i], i == 0, i % 4 == 3, i == 7}) begin
        errors++;
        $display("FAIL trans_px%0d got v=%b d=%h sof/eol/eof=%b%b%b required d=%h", i, bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof, exp[i]);
      end
    end
    checks++;
    if (frame_edge_cnt !== 4'd3) begin
      errors++;
      $display("FAIL trans_count got %0d required 3", frame_edge_cnt);
    end
  endtask

  task automatic test_hyst();
    logic [7:0] px  [8];
    logic [7:0] exp [8];
    px  = '{8'h50, 8'hC8, 8'h50, 8'h30, 8'h50, 8'h50, 8'hC0, 8'h40};
    exp = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF};
    cfg_mode = 2'd2; cfg_thr_hi = 8'hC0; cfg_thr_lo = 8'h40;
    for (int i = 0; i < 8; i++) begin
      send_pix(px[i]);
      checks++;
      if ({bus.m_valid, bus.m_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL hyst_px%0d got v=%b d=%h required d=%h", i, bus.m_valid, bus.m_data, exp[i]);
      end
    end
    checks++;
    if (frame_edge_cnt !== 4'd4) begin
      errors++;
      $display("FAIL hyst_count got %0d required 4", frame_edge_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] px  [8];
    logic [7:0] exp [8];
    px  = '{8'h90, 8'h90, 8'h10, 8'h90, 8'h90, 8'h10, 8'h10, 8'h90};
    exp = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF};
    cfg_mode = 2'd0; cfg_thr_hi = 8'h80;
    send_pix(px[0]);
    send_pix(px[1]);
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = px[2];
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.s_ready, bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof} !== {1'b0, 1'b1, 8'hFF, 3'b000}) begin
        errors++;
        $display("FAIL bp_hold_c%0d got rdy=%b v=%b d=%h tags=%b%b%b required rdy=0 v=1 d=ff tags=000", c, bus.s_ready, bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof);
      end
    end
    bus.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    checks++;
    if ({bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof} !== {1'b1, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL bp_release got v=%b d=%h tags=%b%b%b required v=1 d=00 tags=000", bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof);
    end
    for (int i = 3; i < 8; i++) begin
      send_pix(px[i]);
      checks++;
      if ({bus.m_valid, bus.m_data, bus.m_eol, bus.m_eof} !== {1'b1, exp[i], i % 4 == 3, i == 7}) begin
        errors++;
        $display("FAIL bp_px%0d got v=%b d=%h eol/eof=%b%b required d=%h", i, bus.m_valid, bus.m_data, bus.m_eol, bus.m_eof, exp[i]);
      end
    end
    checks++;
    if (frame_edge_cnt !== 4'd5) begin
      errors++;
      $display("FAIL bp_count got %0d required 5", frame_edge_cnt);
    end
  endtask

  task automatic test_cfg_change();
    logic [7:0] px  [8];
    logic [7:0] exp [8];
    px  = '{8'h90, 8'h10, 8'hA0, 8'h20, 8'h30, 8'hC0, 8'h00, 8'hFF};
    exp = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF};
    cfg_mode = 2'd0; cfg_thr_hi = 8'h80;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        cfg_mode = 2'd3; cfg_thr_hi = 8'h10;
      end
      send_pix(px[i]);
      checks++;
      if ({bus.m_valid, bus.m_data} !== {1'b1, exp[i]}) begin
        errors++;
        $display("FAIL cfg_frame0_px%0d got v=%b d=%h required d=%h", i, bus.m_valid, bus.m_data, exp[i]);
      end
    end
    checks++;
    if (frame_edge_cnt !== 4'd4) begin
      errors++;
      $display("FAIL cfg_frame0_count got %0d required 4", frame_edge_cnt);
    end
    px = '{8'h12, 8'h34, 8'h81, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h05};
    for (int i = 0; i < 8; i++) begin
      send_pix(px[i]);
      checks++;
      if ({bus.m_valid, bus.m_data} !== {1'b1, px[i]}) begin
        errors++;
        $display("FAIL cfg_bypass_px%0d got v=%b d=%h required d=%h", i, bus.m_valid, bus.m_data, px[i]);
      end
    end
    checks++;
    if (frame_edge_cnt !== 4'd6) begin
      errors++;
      $display("FAIL cfg_bypass_count got %0d required 6", frame_edge_cnt);
    end
  endtask

  task automatic test_sync_clr();
    logic [7:0] px [8];
    px = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF};
    cfg_mode = 2'd0; cfg_thr_hi = 8'h80;
    for (int i = 0; i < 5; i++) send_pix(8'hFF);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hFF;
    sync_clr    = 1'b1;
    @(posedge clk);
    #1;
    sync_clr    = 1'b0;
    bus.s_valid = 1'b0;
    checks++;
    if ({bus.m_valid, frame_done, frame_edge_cnt} !== {1'b0, 1'b0, 4'd6}) begin
      errors++;
      $display("FAIL sclr_state got v=%b done=%b cnt=%0d required 0/0/6", bus.m_valid, frame_done, frame_edge_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      send_pix(px[i]);
      checks++;
      if ({bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof} !== {1'b1, px[i], i == 0, i % 4 == 3, i == 7}) begin
        errors++;
        $display("FAIL sclr_px%0d got v=%b d=%h sof/eol/eof=%b%b%b required d=%h", i, bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol, bus.m_eof, px[i]);
      end
    end
    checks++;
    if (frame_edge_cnt !== 4'd4) begin
      errors++;
      $display("FAIL sclr_count got %0d required 4", frame_edge_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    cfg_mode = 2'd0; cfg_thr_hi = 8'h80;
    for (int i = 0; i < 3; i++) send_pix(8'hFF);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.m_valid, frame_done, frame_edge_cnt} !== {1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL rst_mid got v=%b done=%b cnt=%0d required 0/0/0", bus.m_valid, frame_done, frame_edge_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_pix(8'h00);
    checks++;
    if ({bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_restart got v=%b d=%h sof=%b eol=%b required 1/00/1/0", bus.m_valid, bus.m_data, bus.m_sof, bus.m_eol);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    sync_clr    = 1'b0;
    cfg_mode    = 2'd0;
    cfg_thr_hi  = 8'h00;
    cfg_thr_lo  = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.m_ready = 1'b1;
    test_reset();
    test_thresh();
    test_trans();
    test_hyst();
    test_backpressure();
    test_cfg_change();
    test_sync_clr();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
